// File: rtl/mvp_pkg.sv
// Shared types and constants for the matrix x vector sequencer: FSM states,
// row-tag format carried alongside the dot-product pipeline, default latency.
package mvp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_ROWS = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] row;
  } tag_t;

  localparam int DP_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/mat_vec_sequencer_if.sv
// Producer/consumer handshake bundle of the sequencer: matrix/vector in,
// result vector out. The sequencer takes the slave side.
interface mat_vec_sequencer_if #(
  parameter int WIDTH = 32
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] m_in [16];
  logic signed [WIDTH-1:0] v_in [4];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] r_out [4];

  modport master (
    output in_valid, m_in, v_in, out_ready,
    input  in_ready, out_valid, r_out
  );

  modport slave (
    input  in_valid, m_in, v_in, out_ready,
    output in_ready, out_valid, r_out
  );

endinterface

// File: rtl/mvp_tag_pipe.sv
// Row-tag delay line matching the dot-product unit latency; the tail tag
// tells the sequencer which result row dp_out belongs to on this edge.
module mvp_tag_pipe
  import mvp_pkg::*;
#(
  parameter int DEPTH = DP_LATENCY_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  tag_t push_tag,
  output tag_t tail_tag
);

  tag_t tag_p [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) tag_p[i] <= '0;
    end else begin
      tag_p[0] <= push_tag;
      for (int i = 1; i < DEPTH; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  assign tail_tag = tag_p[DEPTH-1];

endmodule

// File: rtl/mat_vec_sequencer.sv
// Feeds a captured 4x4 matrix row by row, with the captured vector, into an
// external pipelined dot-product unit and gathers the four results by row tag.
module mat_vec_sequencer
  import mvp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DP_LATENCY = DP_LATENCY_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  mat_vec_sequencer_if.slave      bus,
  output logic                    busy,
  output logic signed [WIDTH-1:0] dp_x0,
  output logic signed [WIDTH-1:0] dp_x1,
  output logic signed [WIDTH-1:0] dp_x2,
  output logic signed [WIDTH-1:0] dp_x3,
  output logic signed [WIDTH-1:0] dp_y0,
  output logic signed [WIDTH-1:0] dp_y1,
  output logic signed [WIDTH-1:0] dp_y2,
  output logic signed [WIDTH-1:0] dp_y3,
  input  logic signed [WIDTH-1:0] dp_out
);

  state_t                  state;
  logic [1:0]              row_cnt;
  logic                    out_valid_q;
  logic signed [WIDTH-1:0] m_p0 [16];
  logic signed [WIDTH-1:0] v_p0 [4];
  logic signed [WIDTH-1:0] r_q  [4];
  logic                    issuing;
  tag_t                    push_tag;
  tag_t                    tail_tag;

  assign issuing       = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.r_out     = r_q;

  always_comb begin
    push_tag       = '0;
    push_tag.valid = issuing;
    push_tag.row   = row_cnt;
  end

  // Operands come straight from captured state so the unit samples row k at E(k+1).
  always_comb begin
    dp_x0 = '0;
    dp_x1 = '0;
    dp_x2 = '0;
    dp_x3 = '0;
    dp_y0 = '0;
    dp_y1 = '0;
    dp_y2 = '0;
    dp_y3 = '0;
    if (issuing) begin
      dp_x0 = m_p0[{row_cnt, 2'd0}];
      dp_x1 = m_p0[{row_cnt, 2'd1}];
      dp_x2 = m_p0[{row_cnt, 2'd2}];
      dp_x3 = m_p0[{row_cnt, 2'd3}];
      dp_y0 = v_p0[0];
      dp_y1 = v_p0[1];
      dp_y2 = v_p0[2];
      dp_y3 = v_p0[3];
    end
  end

  mvp_tag_pipe #(
    .DEPTH(DP_LATENCY)
  ) u_tag_pipe (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .push_tag(push_tag),
    .tail_tag(tail_tag)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      row_cnt     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 16; i++) m_p0[i] <= '0;
      for (int i = 0; i < N_ROWS; i++) begin
        v_p0[i] <= '0;
        r_q[i]  <= '0;
      end
    end else begin
      // Results are written whenever a tagged row leaves the pipe, in any state.
      if (tail_tag.valid) r_q[tail_tag.row] <= dp_out;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            m_p0    <= bus.m_in;
            v_p0    <= bus.v_in;
            row_cnt <= '0;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'(N_ROWS - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (tail_tag.valid && tail_tag.row == 2'(N_ROWS - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Directed bench for mat_vec_sequencer with a behavioural pipelined
// dot-product unit and a queue of expected result vectors.
module tb_mat_vec_sequencer;

  localparam int W = 32;
  localparam int L = 3;

  typedef logic [3:0][W-1:0] res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mat_vec_sequencer_if #(.WIDTH(W)) bus ();

  logic                busy;
  logic signed [W-1:0] dp_x0, dp_x1, dp_x2, dp_x3;
  logic signed [W-1:0] dp_y0, dp_y1, dp_y2, dp_y3;
  logic signed [W-1:0] dp_out;

  mat_vec_sequencer #(
    .WIDTH     (W),
    .DP_LATENCY(L)
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus),
    .busy    (busy),
    .dp_x0   (dp_x0),
    .dp_x1   (dp_x1),
    .dp_x2   (dp_x2),
    .dp_x3   (dp_x3),
    .dp_y0   (dp_y0),
    .dp_y1   (dp_y1),
    .dp_y2   (dp_y2),
    .dp_y3   (dp_y3),
    .dp_out  (dp_out)
  );

  // Dot-product unit stand-in: L register stages, no reset.
  logic signed [W-1:0] dp_pipe [L];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_x0 * dp_y0 + dp_x1 * dp_y1 + dp_x2 * dp_y2 + dp_x3 * dp_y3;
    for (int i = 1; i < L; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_out = dp_pipe[L-1];

  logic signed [W-1:0] mat [16];
  logic signed [W-1:0] vec [4];
  res_t exp_q [$];

  function automatic res_t model();
    res_t r;
    logic signed [W-1:0] acc;
    for (int k = 0; k < 4; k++) begin
      acc = '0;
      for (int i = 0; i < 4; i++) acc = acc + mat[4*k+i] * vec[i];
      r[k] = acc;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [W-1:0] obs,
                     input logic signed [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair();
    bus.m_in     = mat;
    bus.v_in     = vec;
    bus.in_valid = 1'b1;
  endtask

  task automatic accept(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, W'(bus.in_ready), 1);
    step();
    acc_cyc = cyc;
    exp_q.push_back(model());
  endtask

  task automatic collect(input string tag, input int want_lat);
    int   n = 0;
    res_t e;
    while (!bus.out_valid && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_out_valid"}, W'(bus.out_valid), 1);
    if (want_lat > 0) chk({tag, "_latency"}, cyc - acc_cyc, want_lat);
    chk({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 4; k++) chk($sformatf("%s_r%0d", tag, k), bus.r_out[k], e[k]);
    end
  endtask

  task automatic clear_mat();
    for (int i = 0; i < 16; i++) mat[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc_a;
    res_t snap;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus.m_in[i] = '0;
    for (int i = 0; i < 4; i++) bus.v_in[i] = '0;
    repeat (3) step();

    // Reset state
    chk("rst_in_ready", W'(bus.in_ready), 1);
    chk("rst_out_valid", W'(bus.out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_r_out0", bus.r_out[0], 0);
    chk("rst_dp_x0", dp_x0, 0);
    rst_n = 1'b1;
    step();

    // Identity matrix
    clear_mat();
    for (int i = 0; i < 4; i++) mat[5*i] = 1;
    vec = '{1, 2, 3, 4};
    bus.out_ready = 1'b1;
    drive_pair();
    accept("ident");
    bus.in_valid = 1'b0;
    collect("ident", 7);
    step();
    chk("ident_pulse", W'(bus.out_valid), 0);
    chk("ident_in_ready", W'(bus.in_ready), 1);

    // Row ordering on the dot-product operands
    for (int i = 0; i < 16; i++) mat[i] = W'(i + 1);
    vec = '{1, 1, 1, 1};
    drive_pair();
    accept("rows");
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("rows_dp_x0_%0d", j), dp_x0, W'(4*j + 1));
      chk($sformatf("rows_dp_x3_%0d", j), dp_x3, W'(4*j + 4));
      chk($sformatf("rows_dp_y2_%0d", j), dp_y2, 1);
      step();
    end
    chk("rows_dp_x0_after", dp_x0, 0);
    chk("rows_dp_y0_after", dp_y0, 0);
    collect("rows", 7);
    step();

    // Signed values; inputs scrambled after acceptance
    clear_mat();
    mat[0] = -1; mat[1] = 2; mat[2] = -3; mat[3] = 4;
    vec = '{5, -6, 7, 8};
    drive_pair();
    accept("signed");
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) bus.m_in[i] = 77;
    bus.v_in = '{9, 9, 9, 9};
    collect("signed", 7);
    step();

    // Output backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mat[i] = W'(i - 8);
    vec = '{2, -1, 3, -2};
    drive_pair();
    accept("bp");
    bus.in_valid = 1'b0;
    snap = exp_q[0];
    collect("bp", 7);
    clear_mat();
    mat[15] = 3;
    vec = '{0, 0, 0, 5};
    drive_pair();
    for (int j = 0; j < 10; j++) begin
      step();
      chk($sformatf("bp_hold_valid_%0d", j), W'(bus.out_valid), 1);
      chk($sformatf("bp_hold_in_ready_%0d", j), W'(bus.in_ready), 0);
      chk($sformatf("bp_hold_r1_%0d", j), bus.r_out[1], snap[1]);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", W'(bus.in_ready), 1);
    chk("bp_release_out_valid", W'(bus.out_valid), 0);
    accept("bp2");
    bus.in_valid = 1'b0;
    collect("bp2", 7);
    step();

    // Reset during DRAIN
    for (int i = 0; i < 16; i++) mat[i] = W'(3 * i + 1);
    vec = '{1, 2, 1, 2};
    drive_pair();
    accept("rstd");
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("rstd_busy", W'(busy), 1);
    chk("rstd_r0_written", bus.r_out[0], exp_q[exp_q.size()-1][0]);
    rst_n = 1'b0;
    #1;
    chk("rstd_out_valid", W'(bus.out_valid), 0);
    chk("rstd_in_ready", W'(bus.in_ready), 1);
    chk("rstd_r0", bus.r_out[0], 0);
    void'(exp_q.pop_back());
    step();
    rst_n = 1'b1;
    repeat (8) step();
    for (int k = 0; k < 4; k++) chk($sformatf("rstd_stale_r%0d", k), bus.r_out[k], 0);
    chk("rstd_stale_valid", W'(bus.out_valid), 0);
    clear_mat();
    for (int i = 0; i < 4; i++) mat[5*i] = W'(i + 2);
    vec = '{-3, 4, -5, 6};
    drive_pair();
    accept("rstd_next");
    bus.in_valid = 1'b0;
    collect("rstd_next", 7);
    step();

    // Back-to-back with in_valid held high
    for (int i = 0; i < 16; i++) mat[i] = W'(i % 5) - 2;
    vec = '{4, 3, 2, 1};
    drive_pair();
    accept("b2b_a");
    acc_a = acc_cyc;
    for (int i = 0; i < 16; i++) mat[i] = W'((i * 7) % 11);
    vec = '{-1, 2, -3, 4};
    drive_pair();
    collect("b2b_a", 7);
    accept("b2b_b");
    bus.in_valid = 1'b0;
    chk("b2b_spacing", acc_cyc - acc_a, 9);
    collect("b2b_b", 7);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
